// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command front-end for the 8-bit combinational compare/logic ALU. Commands
// (opcode + two operands) enter through a valid/ready handshake and are queued
// in a small FIFO. A four-state sequencer pops one command at a time, presents
// it to the ALU from registered outputs, waits one cycle for the ALU to settle,
// captures the result and offers it on a valid/ready response channel.
//
// Optional feature macro: ALU_SEQ_FLAGS_EN
//   defined   -> rsp_flags port exists, {neg, zero} of rsp_data registered
//                alongside the result (both 0 on an error response)
//   undefined -> no rsp_flags port, no flag logic
//
// Parameters
//   DEPTH       command FIFO entries (power of two, at least 2)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   FIFO not full (derived from registered level)
//   cmd_ctrl    opcode (legal 2..11)
//   cmd_a/b     operands, signed two's complement
//   alu_ctrl    registered opcode to the ALU
//   alu_a/b     registered operands to the ALU
//   alu_s       combinational ALU result
//   rsp_valid   response available
//   rsp_ready   response consumed (only looked at while holding a response)
//   rsp_data    captured result (0 for an illegal opcode)
//   rsp_ctrl    opcode of the response
//   rsp_err     opcode was illegal
//   rsp_flags   {neg, zero} of rsp_data (ALU_SEQ_FLAGS_EN only)
//   fifo_level  entries currently held in the FIFO
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_ctrl,
    input  logic [7:0]                 cmd_a,
    input  logic [7:0]                 cmd_b,
    output logic [3:0]                 alu_ctrl,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    input  logic [7:0]                 alu_s,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [7:0]                 rsp_data,
    output logic [3:0]                 rsp_ctrl,
    output logic                       rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
    output logic [1:0]                 rsp_flags,
`endif
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = 4 + 8 + 8;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    // -------------------------------------------------------------------------
    // Command FIFO
    // -------------------------------------------------------------------------
    // Storage carries no reset: emptiness is tracked by the pointers and level,
    // so stale contents after reset are never observed.
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] head_entry;
    logic [3:0]         head_ctrl;
    logic [7:0]         head_a;
    logic [7:0]         head_b;
    logic               head_illegal;

    assign cmd_ready  = (level_reg != DEPTH_LVL);
    assign push       = cmd_valid && cmd_ready;
    assign fifo_level = level_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_ctrl, cmd_a, cmd_b};
        end
    end

    // Pop decisions use the registered level, so an entry written this cycle
    // only becomes visible to the sequencer on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head_entry   = fifo_mem[rd_ptr_reg];
    assign head_ctrl    = head_entry[19:16];
    assign head_a       = head_entry[15:8];
    assign head_b       = head_entry[7:0];
    assign head_illegal = (head_ctrl < 4'd2) || (head_ctrl > 4'd11);

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   capture_en;
    logic   release_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        capture_en = 1'b0;
        release_en = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (level_reg != '0) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            // One full cycle with the operands stable lets the ALU settle.
            ST_ISSUE: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture_en = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    release_en = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // ALU drive and response registers
    // -------------------------------------------------------------------------
    logic [3:0] alu_ctrl_reg;
    logic [7:0] alu_a_reg;
    logic [7:0] alu_b_reg;
    logic       err_pend_reg;
    logic       rsp_valid_reg;
    logic [7:0] rsp_data_reg;
    logic [3:0] rsp_ctrl_reg;
    logic       rsp_err_reg;

    // alu_* only change on a pop, so they keep the last issued command between
    // transactions and stay frozen while a response is being held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl_reg  <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            err_pend_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_ctrl_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (pop) begin
                alu_ctrl_reg <= head_ctrl;
                alu_a_reg    <= head_a;
                alu_b_reg    <= head_b;
                rsp_ctrl_reg <= head_ctrl;
                err_pend_reg <= head_illegal;
            end
            if (capture_en) begin
                // Illegal opcodes still reach the ALU, but the response is
                // forced to zero regardless of what the ALU returns.
                rsp_data_reg  <= err_pend_reg ? 8'h00 : alu_s;
                rsp_err_reg   <= err_pend_reg;
                rsp_valid_reg <= 1'b1;
            end
            if (release_en) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign alu_ctrl  = alu_ctrl_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_ctrl  = rsp_ctrl_reg;
    assign rsp_err   = rsp_err_reg;

`ifdef ALU_SEQ_FLAGS_EN
    // Flags are derived from the same value that lands in rsp_data, so they
    // track it exactly; an error response clears both.
    logic [1:0] rsp_flags_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_flags_reg <= 2'b00;
        end else if (capture_en) begin
            if (err_pend_reg) begin
                rsp_flags_reg <= 2'b00;
            end else begin
                rsp_flags_reg <= {alu_s[7], (alu_s == 8'h00)};
            end
        end
    end

    assign rsp_flags = rsp_flags_reg;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [3:0] cmd_ctrl  = 4'd0;
    logic [7:0] cmd_a     = 8'd0;
    logic [7:0] cmd_b     = 8'd0;
    logic       cmd_ready;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_s;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [3:0] rsp_ctrl;
    logic       rsp_err;
    logic [2:0] fifo_level;
`ifdef ALU_SEQ_FLAGS_EN
    logic [1:0] rsp_flags;
`endif

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ctrl   (cmd_ctrl),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_ctrl   (rsp_ctrl),
        .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_flags  (rsp_flags),
`endif
        .fifo_level (fifo_level)
    );

    // ------------------------------------------------------------------
    // ALU stand-in and reference model
    // ------------------------------------------------------------------
    function automatic logic is_legal(input logic [3:0] c);
        return (c >= 4'd2) && (c <= 4'd11);
    endfunction

    function automatic logic [7:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'd2:    return a;
            4'd3:    return a + 8'd1;
            4'd4:    return a - 8'd1;
            4'd5:    return a & b;
            4'd6:    return ~(a | b);
            4'd7:    return a ^ b;
            4'd8:    return ~(a ^ b);
            4'd9:    return {7'd0, $signed(a) > $signed(b)};
            4'd10:   return {7'd0, $signed(a) < $signed(b)};
            4'd11:   return {7'd0, a == b};
            default: return 8'h00;
        endcase
    endfunction

    // Illegal opcodes return a nonzero pattern here so that the sequencer's
    // forcing of rsp_data to zero is actually observable.
    always_comb alu_s = is_legal(alu_ctrl) ? alu_fn(alu_ctrl, alu_a, alu_b) : 8'hA5;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [7:0] data;
        logic       err;
        logic [1:0] flags;
    } exp_t;

    function automatic exp_t model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.ctrl  = c;
        e.err   = !is_legal(c);
        e.data  = e.err ? 8'h00 : alu_fn(c, a, b);
        e.flags = e.err ? 2'b00 : {e.data[7], (e.data == 8'h00)};
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    exp_t        exp_q[$];
    int          n_acc     = 0;
    int          n_rsp     = 0;
    logic        hold_prev = 1'b0;
    logic [63:0] hold_snap = '0;

    function automatic logic [63:0] snap();
        return {30'd0, rsp_valid, rsp_data, rsp_ctrl, rsp_err, alu_ctrl, alu_a, alu_b};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_stable", snap(), hold_snap);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_ctrl", rsp_ctrl, e.ctrl);
                    check("sb_data", rsp_data, e.data);
                    check("sb_err", rsp_err, e.err);
`ifdef ALU_SEQ_FLAGS_EN
                    check("sb_flags", rsp_flags, e.flags);
`endif
                    $display("rsp %0d: ctrl=%0d data=0x%02h err=%0b", n_rsp, rsp_ctrl, rsp_data, rsp_err);
                end
                n_rsp++;
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(model(cmd_ctrl, cmd_a, cmd_b));
                n_acc++;
            end
            hold_prev = rsp_valid && !rsp_ready;
            hold_snap = snap();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single command into an idle, empty sequencer with rsp_ready high,
    // checking the exact cycle-by-cycle latency.
    task automatic run_single(input string tag, input logic [3:0] c, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] exp_data,
                              input logic exp_err, input logic [1:0] exp_flags);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_ctrl  = c;
        cmd_a     = a;
        cmd_b     = b;
        check({tag, "_ready_t"}, cmd_ready, 1);
        tick();                                  // t: accepted
        cmd_valid = 1'b0;
        check({tag, "_valid_t1"}, rsp_valid, 0);
        tick();                                  // t+1: popped
        tick();                                  // t+2
        check({tag, "_alu_ctrl"}, alu_ctrl, c);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, {a, b});
        check({tag, "_valid_t2"}, rsp_valid, 0);
        tick();                                  // t+3
        check({tag, "_valid_t3"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_ctrl"}, rsp_ctrl, c);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_flags"}, rsp_flags, exp_flags);
`else
        if (exp_flags === 2'bxx) check({tag, "_flags_arg"}, 0, 1);
`endif
        tick();                                  // consumed
        check({tag, "_valid_after"}, rsp_valid, 0);
    endtask

    task automatic drain(input string tag);
        int done;
        done      = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (exp_q.size() == 0 && !rsp_valid && fifo_level == 0) begin
                done = 1;
                break;
            end
        end
        check({tag, "_drained"}, done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp"}, {rsp_valid, rsp_data, rsp_ctrl, rsp_err}, 0);
        check({tag, "_alu"}, {alu_ctrl, alu_a, alu_b}, 0);
        check({tag, "_level"}, fifo_level, 0);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_flags"}, rsp_flags, 0);
`endif
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int a0;
        int r0;
        int stale;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        tick();

        // Directed opcodes
        run_single("inc7f", 4'd3, 8'h7F, 8'h00, 8'h80, 1'b0, 2'b10);
        run_single("gt",    4'd9, 8'hFF, 8'h01, 8'h00, 1'b0, 2'b01);
        run_single("lt",    4'd10, 8'hFF, 8'h01, 8'h01, 1'b0, 2'b00);
        run_single("ill12", 4'd12, 8'h55, 8'h00, 8'h00, 1'b1, 2'b00);
        run_single("dec01", 4'd4, 8'h01, 8'h00, 8'h00, 1'b0, 2'b01);
        run_single("dec00", 4'd4, 8'h00, 8'h00, 8'hFF, 1'b0, 2'b10);
        run_single("ill0",  4'd0, 8'h3C, 8'hC3, 8'h00, 1'b1, 2'b00);

        // Fill with rsp_ready low: DEPTH+1 absorbed
        rsp_ready = 1'b0;
        a0        = n_acc;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cmd_ctrl = 4'(2 + (i % 10));
            cmd_a    = 8'($urandom);
            cmd_b    = 8'($urandom);
            tick();
        end
        check("fill_accepts", n_acc - a0, DEPTH + 1);
        check("fill_cmd_ready", cmd_ready, 0);
        check("fill_level", fifo_level, DEPTH);
        check("fill_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_ctrl = 4'(2 + (i % 10));
            cmd_a    = 8'($urandom);
            cmd_b    = 8'($urandom);
            tick();
        end
        check("refill_accepts", n_acc - a0, DEPTH + 2);
        check("refill_level", fifo_level, DEPTH);
        check("refill_cmd_ready", cmd_ready, 0);
        drain("fill");

        // Reset during CAPTURE with commands queued
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_ctrl = 4'd7;
            cmd_a    = 8'(i * 17);
            cmd_b    = 8'h0F;
            tick();
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_values("midrst");
        r0 = n_rsp;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) stale++;
        end
        check("no_stale_valid", stale, 0);
        check("no_stale_rsp", n_rsp - r0, 0);
        check("post_rst_level", fifo_level, 0);
        run_single("postrst", 4'd7, 8'h3C, 8'h0F, 8'h33, 1'b0, 2'b00);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom % 3) != 0;
            cmd_ctrl  = 4'($urandom_range(0, 15));
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            rsp_ready = ($urandom % 2) != 0;
            tick();
            if (fifo_level > DEPTH) check("level_bound", fifo_level, DEPTH);
        end
        drain("rand");
        check("rand_all_answered", n_rsp, n_acc - 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end that drives the 8-bit combinational compare/logic ALU. It accepts opcode/operand commands through a valid/ready handshake and buffers them in a small FIFO. It issues each command to the ALU from registered outputs, captures the ALU result, and returns it through a valid/ready response channel. It sits between the bus-side control logic and the ALU, and is the only block that drives the ALU's `ctrl`, `a` and `b` inputs.

## Interface
- `DEPTH`, 4: command FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full` and is registered-state-derived.
- `cmd_ctrl`  in  4  opcode. Legal values: 2 = pass A, 3 = A+1, 4 = A−1, 5, 6 = NOR, 7 = XOR, 8 = XNOR, 9 = GT, 10 = LT, 11 = EQ.
- `cmd_a`, `cmd_b`  in  8  operands, signed two's complement.
- `alu_ctrl`  out  4  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  8  registered operands to the ALU.
- `alu_s`  in  8  combinational ALU result.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  8  captured result.
- `rsp_ctrl`  out  4  opcode of this response.
- `rsp_err`  out  1  the opcode was illegal (0, 1, 12–15).
- `fifo_level`  out  $clog2(DEPTH)+1  entries currently in the FIFO.
- `rsp_flags`  out  2  {neg, zero} of `rsp_data`; present only with `ALU_SEQ_FLAGS_EN`.

## Operation
- FIFO behaviour:
  - A push occurs when `cmd_valid && cmd_ready`.
  - A pop occurs only in IDLE when the FIFO is not empty.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave `fifo_level` unchanged.
  - A push into an empty FIFO is not poppable until the following cycle.
- FSM states IDLE, ISSUE, CAPTURE, HOLD:
  - IDLE → ISSUE: FIFO not empty. Pop the head into the `alu_*` registers, `rsp_ctrl`, and an internal error bit.
  - ISSUE → CAPTURE: unconditional. The ALU output settles.
  - CAPTURE → HOLD: `rsp_data` ← `alu_s`, or 8'h00 if the error bit is set. Set `rsp_err` ← error bit and `rsp_valid` ← 1.
  - HOLD → IDLE: on `rsp_ready`. `rsp_valid` ← 0.
  - HOLD otherwise: all `rsp_*` and `alu_*` outputs hold stable.
- Illegal opcodes follow the same timing. They are still presented on `alu_ctrl` (the ALU yields 0), and `rsp_data` is forced to 0.
- Results are taken verbatim from `alu_s`. No arithmetic is done in this block.
- `alu_*` hold their last issued values between commands.
- Reset (asserted asynchronously, at any time):
  - FIFO emptied; `fifo_level` = 0; state = IDLE.
  - `cmd_ready` = 1; `rsp_valid` = 0; `rsp_data` = 0; `rsp_ctrl` = 0; `rsp_err` = 0.
  - `alu_ctrl` = 0; `alu_a` = 0; `alu_b` = 0; `rsp_flags` = 0.
  - Any command that is in flight or buffered is discarded, and no response is produced for it.

## Timing
- Latency, with the command accepted in cycle t into an empty FIFO while the FSM is in IDLE:
  - t+1: the command is popped.
  - t+2: the `alu_*` outputs are valid.
  - t+3: `rsp_valid` = 1.
- Minimum issue interval is 4 cycles per command: ISSUE, CAPTURE, HOLD with `rsp_ready` = 1, then IDLE.
- `rsp_ready` may be held high permanently. `rsp_ready` is ignored outside HOLD.
- `cmd_ready` deasserts in the cycle after the FIFO becomes full. It reasserts in the cycle after a pop.
- With `rsp_ready` held low, DEPTH+1 commands are absorbed: one sits in HOLD and DEPTH sit in the FIFO.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined:
  - The `rsp_flags` port exists.
  - The flags are registered in CAPTURE together with `rsp_data`: zero = (`rsp_data` == 0), neg = `rsp_data`[7].
  - Both flags are 0 on an error response.
- `ALU_SEQ_FLAGS_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Opcode 3, a = 8'h7F, `rsp_ready` = 1: `alu_ctrl` = 3 at t+2; `rsp_valid` at t+3; `rsp_data` = 8'h80, `rsp_err` = 0.
- Opcode 9, a = 8'hFF, b = 8'h01: `rsp_data` = 8'h00 (signed compare, −1 > 1 is false). Then opcode 10 with the same operands: `rsp_data` = 8'h01.
- `cmd_valid` held high, `rsp_ready` low, DEPTH = 4:
  - Exactly 5 commands accepted; `cmd_ready` = 0 and `fifo_level` = 4 thereafter.
  - One response handshake: one more command accepted.
  - Responses arrive in push order.
- Opcode 12, a = 8'h55: `rsp_err` = 1, `rsp_data` = 8'h00, `rsp_ctrl` = 12, same latency as a legal opcode.
- Three commands queued, `rst_n` pulsed low during CAPTURE:
  - All outputs at their reset values immediately.
  - No stale response after release.
  - A new command completes normally.
- With `ALU_SEQ_FLAGS_EN`: opcode 4, a = 8'h01 gives `rsp_flags` = 2'b01. Opcode 4, a = 8'h00 gives `rsp_data` = 8'hFF and `rsp_flags` = 2'b10.
